// File: rtl/cpu15_mem_pkg.sv
// rtl/cpu15_mem_pkg.sv - shared constants and state enum for the mega_ram master
package cpu15_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_LEN_W  = 4;

    // Memory-mapped IO words; the master itself treats them as plain RAM words.
    localparam logic [MEM_ADDR_W-1:0] IO64_ADDR = 8'd64;
    localparam logic [MEM_ADDR_W-1:0] IO65_ADDR = 8'd65;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RESP
    } mm_state_t;

endpackage

// File: rtl/mem_burst_ctr.sv
// rtl/mem_burst_ctr.sv - burst address incrementer and remaining-beat down-counter
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture load_addr / load_len (start of a transaction)
//   step              advance to the next beat: addr+1 (wrapping), remaining-1
//   load_addr         start address
//   load_len          beats minus one
//   addr              current beat address (drives the RAM address directly)
//   last              current beat is the final one
module mem_burst_ctr #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_len;
        end else if (step) begin
            // Natural overflow gives the modulo-2^ADDR_W wrap.
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == '0);

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - request/response master for mega_ram: single writes, read bursts
//
// Ports:
//   CLK, RESET_N                       clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY                request handshake
//   REQ_WE, REQ_ADDR, REQ_LEN, REQ_WDATA   request fields (REQ_LEN = beats-1, reads only)
//   RSP_VALID/RSP_READY                response beat handshake
//   RSP_DATA, RSP_LAST                 read data (0 on write ack), final-beat flag
//   RAM_ADDR, RAM_IN, RAM_WEN, RAM_OUT direct mega_ram connection (one-cycle read latency)
module mem_master
    import cpu15_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [3:0]        REQ_LEN,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_LAST,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              RAM_WEN,
    input  logic [DATA_W-1:0] RAM_OUT
);

    mm_state_t state, state_nxt;

    // Holds REQ_READY low through reset and releases it on the first edge after.
    logic init_done;

    logic              accept;
    logic              ctr_load;
    logic              ctr_step;
    logic              ctr_last;
    logic [ADDR_W-1:0] ctr_addr;
    logic [DATA_W-1:0] ram_in_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_last_q;

    assign accept = REQ_VALID && REQ_READY;

    mem_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (MEM_LEN_W)
    ) u_burst_ctr (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .load      (ctr_load),
        .step      (ctr_step),
        .load_addr (REQ_ADDR),
        .load_len  (REQ_WE ? 4'd0 : REQ_LEN),
        .addr      (ctr_addr),
        .last      (ctr_last)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = REQ_WE ? WR : RD_ISSUE;
            WR:       state_nxt = RESP;
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = RESP;
            RESP:     if (RSP_READY) state_nxt = ctr_last ? IDLE : RD_ISSUE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = (state == IDLE) && init_done;
        RSP_VALID = (state == RESP);
        RAM_WEN   = (state == WR);
        ctr_load  = accept;
        ctr_step  = (state == RESP) && RSP_READY && !ctr_last;
    end

    // Response register: loaded once per beat, frozen through RESP so
    // back-pressure never disturbs the presented beat.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ram_in_q   <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            if (accept) ram_in_q <= REQ_WDATA;
            if (state == WR) begin
                rsp_data_q <= '0;
                rsp_last_q <= 1'b1;
            end else if (state == RD_CAPT) begin
                rsp_data_q <= RAM_OUT;
                rsp_last_q <= ctr_last;
            end else if (state == RESP && RSP_READY) begin
                rsp_last_q <= 1'b0;
            end
        end
    end

    assign RSP_DATA = rsp_data_q;
    assign RSP_LAST = rsp_last_q;
    assign RAM_ADDR = ctr_addr;
    assign RAM_IN   = ram_in_q;

endmodule
